serial_sub_ctrl: RTL and testbench

SERIAL_SUB_CTRL -- requirements
Module: serial_sub_ctrl

---
 rtl/serial_sub_pkg.sv | 12 +
 rtl/full_sub.sv | 13 +
 rtl/serial_sub_ctrl.sv | 116 +++++++++++
 tb/tb_serial_sub_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - shared FSM encoding and default operand width for serial_sub_ctrl
package serial_sub_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/full_sub.sv
// rtl/full_sub.sv - combinational one-bit full subtractor: diff = a - b - boin
module full_sub (
    input  logic a,
    input  logic b,
    input  logic boin,
    output logic diff,
    output logic borrow
);

    assign diff   = a ^ b ^ boin;
    assign borrow = (~a & b) | (~(a ^ b) & boin);

endmodule

// File: rtl/serial_sub_ctrl.sv
// rtl/serial_sub_ctrl.sv - bit-serial subtractor, one result bit per cycle, LSB first.
// Optional SERIAL_SUB_OVF_EN adds a registered two's-complement overflow output.
module serial_sub_ctrl
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
    output logic             ovf,
`endif
    output logic             bout
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] sr_a;
    logic [WIDTH-1:0] sr_b;
    logic [WIDTH-1:0] sr_d;
    logic [WIDTH-1:0] d_next;
    logic             borrow;
    logic [CW-1:0]    cnt;
    logic             cell_diff;
    logic             cell_borrow;
`ifdef SERIAL_SUB_OVF_EN
    logic             a_msb;
    logic             b_msb;
`endif

    full_sub u_cell (
        .a      (sr_a[0]),
        .b      (sr_b[0]),
        .boin   (borrow),
        .diff   (cell_diff),
        .borrow (cell_borrow)
    );

    // Difference bits enter at the MSB so the word is aligned after WIDTH shifts.
    assign d_next = (sr_d >> 1) | (WIDTH'(cell_diff) << (WIDTH - 1));

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (cnt == LAST) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            sr_a   <= '0;
            sr_b   <= '0;
            sr_d   <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            diff   <= '0;
            bout   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            ovf    <= 1'b0;
`endif
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        sr_a   <= a;
                        sr_b   <= b;
                        sr_d   <= '0;
                        borrow <= bin;
                        cnt    <= '0;
`ifdef SERIAL_SUB_OVF_EN
                        a_msb  <= a[WIDTH-1];
                        b_msb  <= b[WIDTH-1];
`endif
                    end
                end
                SHIFT: begin
                    sr_a   <= sr_a >> 1;
                    sr_b   <= sr_b >> 1;
                    sr_d   <= d_next;
                    borrow <= cell_borrow;
                    cnt    <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        diff <= d_next;
                        bout <= cell_borrow;
`ifdef SERIAL_SUB_OVF_EN
                        // The final cell's diff bit is the result MSB.
                        ovf  <= (a_msb != b_msb) && (cell_diff != a_msb);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// tb/tb_serial_sub_ctrl.sv - scoreboard bench for serial_sub_ctrl at WIDTH=8 and WIDTH=1
module tb_serial_sub_ctrl;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         bin = 1'b0;
    logic         busy, done, bout;
    logic [W-1:0] diff;

    logic         start1 = 1'b0;
    logic [0:0]   a1 = '0;
    logic [0:0]   b1 = '0;
    logic         bin1 = 1'b0;
    logic         busy1, done1, bout1;
    logic [0:0]   diff1;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf, ovf1;
`endif

    serial_sub_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
        .busy(busy), .done(done), .diff(diff),
`ifdef SERIAL_SUB_OVF_EN
        .ovf(ovf),
`endif
        .bout(bout)
    );

    serial_sub_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .bin(bin1),
        .busy(busy1), .done(done1), .diff(diff1),
`ifdef SERIAL_SUB_OVF_EN
        .ovf(ovf1),
`endif
        .bout(bout1)
    );

    int n_checks = 0;
    int n_fail = 0;
    int n_ops = 0;
    int n_ops1 = 0;
    int dones = 0;
    int dones1 = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
    } exp_t;

    exp_t sb[$];
    exp_t sb1[$];

    // Reference: integer arithmetic on the operands as captured at acceptance.
    function automatic exp_t model(input int w, input int unsigned ai, input int unsigned bi,
                                   input int unsigned ci);
        exp_t e;
        int unsigned mask, r, am, bm, rm;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 1);
        r    = (ai - bi - ci) & mask;
        am   = (ai >> (w - 1)) & 1;
        bm   = (bi >> (w - 1)) & 1;
        rm   = (r >> (w - 1)) & 1;
        e.d  = W'(r);
        e.bo = (ai < bi + ci);
        e.ov = (am != bm) && (rm != am);
        return e;
    endfunction

    logic [W-1:0] last_d = '0;
    logic         last_bo = 1'b0;
    logic         prev_done = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            last_d  = '0;
            last_bo = 1'b0;
            prev_done = 1'b0;
        end else if (done) begin
            dones++;
            check("done_single_pulse", prev_done, 0);
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                check("diff", diff, e.d);
                check("bout", bout, e.bo);
`ifdef SERIAL_SUB_OVF_EN
                check("ovf", ovf, e.ov);
`endif
            end
            last_d  = diff;
            last_bo = bout;
            prev_done = 1'b1;
        end else begin
            check("diff_hold", diff, last_d);
            check("bout_hold", bout, last_bo);
            prev_done = 1'b0;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done1) begin
            dones1++;
            if (sb1.size() == 0) begin
                check("w1_unexpected_done", 1, 0);
            end else begin
                e = sb1.pop_front();
                check("w1_diff", diff1, e.d[0]);
                check("w1_bout", bout1, e.bo);
`ifdef SERIAL_SUB_OVF_EN
                check("w1_ovf", ovf1, e.ov);
`endif
            end
        end
    end

    // Called at a negedge; returns at the negedge after the DONE cycle so a
    // following call lands its start on the earliest accepting edge.
    task automatic op(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic ci,
                      input int poke);
        start = 1'b1; a = ai; b = bi; bin = ci;
        @(posedge clk);
        sb.push_back(model(W, ai, bi, ci));
        n_ops++;
        @(negedge clk);
        start = 1'b0; a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
        check("busy_after_accept", busy, 1);
        for (int k = 1; k <= W; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k < W) begin
                check("busy_shift", busy, 1);
                check("no_done_shift", done, 0);
                start = (k == poke);
                if (k == poke) begin
                    a = '1; b = W'($urandom); bin = 1'($urandom);
                end
            end else begin
                check("done_latency", done, 1);
                check("busy_done", busy, 1);
                start = 1'b0;
            end
        end
        @(posedge clk);
        @(negedge clk);
        check("done_cleared", done, 0);
        check("busy_cleared", busy, 0);
    endtask

    task automatic abort_op();
        start = 1'b1; a = 8'h35; b = 8'h12; bin = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_diff", diff, 0);
        check("abort_bout", bout, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic op1(input logic ai, input logic bi, input logic ci);
        start1 = 1'b1; a1 = ai; b1 = bi; bin1 = ci;
        @(posedge clk);
        sb1.push_back(model(1, 32'(ai), 32'(bi), 32'(ci)));
        n_ops1++;
        @(negedge clk);
        start1 = 1'b0;
        check("w1_busy_shift", busy1, 1);
        check("w1_no_done_shift", done1, 0);
        @(posedge clk);
        @(negedge clk);
        check("w1_done_latency", done1, 1);
        @(posedge clk);
        @(negedge clk);
        check("w1_idle", busy1, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        #12;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_diff", diff, 0);
        check("reset_bout", bout, 0);
`ifdef SERIAL_SUB_OVF_EN
        check("reset_ovf", ovf, 0);
`endif
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        op(8'h35, 8'h12, 1'b0, 0);
        op(8'h12, 8'h35, 1'b0, 0);
        op(8'h00, 8'h00, 1'b1, 0);
        op(8'h35, 8'h12, 1'b0, 2);
        abort_op();
        op(8'h10, 8'h01, 1'b0, 0);
        op(8'h80, 8'h01, 1'b0, 0);
        op(8'h05, 8'h03, 1'b0, 0);
        op(8'hFF, 8'hFF, 1'b1, W - 1);
        repeat (40) op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, W - 1)));

        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            op1(v[2], v[1], v[0]);
        end

        repeat (4) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        check("w1_scoreboard_empty", sb1.size(), 0);
        check("done_count", dones, n_ops);
        check("w1_done_count", dones1, n_ops1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
